// File: rtl/tk1_bus_pkg.sv
// Shared definitions for core register bus masters.
// Holds the copy-master FSM encoding, bus widths and the bus request payload.
package tk1_bus_pkg;

  localparam int unsigned ADDR_W             = 32;
  localparam int unsigned DATA_W             = 32;
  localparam int unsigned ADDR_STEP          = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
  localparam int unsigned CNT_W_DEF          = 16;

  // Clears the byte-offset bits of an address.
  localparam logic [ADDR_W-1:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // Request fields presented to the bus while bus_cs is high.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
  } bus_req_t;

endpackage

// File: rtl/tk1_bus_timeout.sv
// Bus wait-state watchdog shared by bus masters.
// Counts consecutive enabled cycles; expired_c flags the cycle that would
// reach TIMEOUT_CYCLES.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   clear         zero the counter (takes priority over enable)
//   enable        count this cycle (access pending, no ready)
//   expired_c     combinational: this enabled cycle is the TIMEOUT_CYCLES-th wait
module tk1_bus_timeout
  import tk1_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;

  assign expired_c = enable && (count_q == CW'(TIMEOUT_CYCLES - 1));

  // Wait counter; holds at the limit so it never wraps.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      count_q <= '0;
    end else if (enable && !expired_c) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/tk1_bus_copy_master.sv
// Second bus master that copies word_count words from src_addr to dst_addr,
// one outstanding access at a time (read, then write, per word).
// Ports:
//   clk, reset_n                     clock, synchronous active-low reset
//   start, src_addr, dst_addr,
//   word_count, abort                job control (start sampled only when idle)
//   busy, done, error, words_done    job status (all registered)
//   bus_cs, bus_we, bus_address,
//   bus_write_data                   registered bus request
//   bus_read_data, bus_ready         bus response
module tk1_bus_copy_master
  import tk1_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  words_done,
  output logic              bus_cs,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_write_data,
  input  logic [DATA_W-1:0] bus_read_data,
  input  logic              bus_ready
);

  state_e            state_q;
  bus_req_t          req_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [CNT_W-1:0]  remaining_q;

  logic in_xfer_c;
  logic to_clear_c;
  logic to_enable_c;
  logic to_expired_c;

  // Counter restarts whenever an access completes or we leave RD/WR,
  // so it is zero on every RD/WR entry.
  assign in_xfer_c   = (state_q == ST_RD) || (state_q == ST_WR);
  assign to_enable_c = in_xfer_c && !bus_ready;
  assign to_clear_c  = !in_xfer_c || bus_ready;

  tk1_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (to_clear_c),
    .enable   (to_enable_c),
    .expired_c(to_expired_c)
  );

  assign bus_we         = req_q.we;
  assign bus_address    = req_q.address;
  assign bus_write_data = req_q.write_data;

  // Job FSM; request and status flops change together with the state so the
  // bus request never depends combinationally on bus_ready.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      words_done  <= '0;
      bus_cs      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            words_done <= '0;
            error      <= 1'b0;
            if (word_count != '0) begin
              src_q         <= src_addr & WORD_MASK;
              dst_q         <= dst_addr & WORD_MASK;
              remaining_q   <= word_count;
              req_q.we      <= 1'b0;
              req_q.address <= src_addr & WORD_MASK;
              bus_cs        <= 1'b1;
              busy          <= 1'b1;
              state_q       <= ST_RD;
            end else begin
              done    <= 1'b1;
              state_q <= ST_FIN;
            end
          end
        end

        ST_RD: begin
          if (abort) begin
            // A read completing alongside abort is discarded.
            bus_cs  <= 1'b0;
            busy    <= 1'b0;
            state_q <= ST_IDLE;
          end else if (bus_ready) begin
            req_q.we         <= 1'b1;
            req_q.address    <= dst_q;
            req_q.write_data <= bus_read_data;
            state_q          <= ST_WR;
          end else if (to_expired_c) begin
            error   <= 1'b1;
            done    <= 1'b1;
            bus_cs  <= 1'b0;
            busy    <= 1'b0;
            state_q <= ST_FIN;
          end
        end

        ST_WR: begin
          // A completed write always counts, even when aborted in the same cycle.
          if (bus_ready) begin
            words_done  <= words_done + CNT_W'(1);
            src_q       <= src_q + ADDR_W'(ADDR_STEP);
            dst_q       <= dst_q + ADDR_W'(ADDR_STEP);
            remaining_q <= remaining_q - CNT_W'(1);
          end
          if (abort) begin
            req_q.we <= 1'b0;
            bus_cs   <= 1'b0;
            busy     <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (bus_ready) begin
            req_q.we <= 1'b0;
            if (remaining_q == CNT_W'(1)) begin
              done    <= 1'b1;
              bus_cs  <= 1'b0;
              busy    <= 1'b0;
              state_q <= ST_FIN;
            end else begin
              req_q.address <= src_q + ADDR_W'(ADDR_STEP);
              state_q       <= ST_RD;
            end
          end else if (to_expired_c) begin
            req_q.we <= 1'b0;
            error    <= 1'b1;
            done     <= 1'b1;
            bus_cs   <= 1'b0;
            busy     <= 1'b0;
            state_q  <= ST_FIN;
          end
        end

        ST_FIN: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
